// File: rtl/mc14500b_trace_pkg.sv
// Shared types for the MC14500B trace transmitter: FSM state encodings,
// the captured record layout and the default record sync byte.
package mc14500b_trace_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_TRC  = 2'd2,
    S_OUT  = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_START = 2'd1,
    T_DATA  = 2'd2,
    T_STOP  = 2'd3
  } tx_state_e;

  typedef struct packed {
    logic [7:0] trace;
    logic [7:0] out;
  } trace_rec_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_tx.sv
// 8N1 byte transmitter with a valid/ready input. The stop bit ends with one
// T_IDLE cycle, so a byte accepted there follows with no idle gap on the line.
module uart_tx
  import mc14500b_trace_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       TX
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT - 2);

  tx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;

  // Bit sequencer; the line level is registered alongside the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= T_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        T_IDLE: begin
          cnt_q <= '0;
          if (valid) begin
            state_q <= T_START;
            shift_q <= data;
            tx_q    <= 1'b0;
          end else begin
            tx_q <= 1'b1;
          end
        end
        T_START: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            state_q <= T_DATA;
            tx_q    <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        T_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= T_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        T_STOP: begin
          if (cnt_q == STOP_LAST) begin
            cnt_q   <= '0;
            state_q <= T_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= T_IDLE;
          cnt_q   <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign ready = (state_q == T_IDLE);
  assign TX    = tx_q;

endmodule

// File: rtl/mc14500b_trace_uart.sv
// Captures {TRACE, OUTPUT} on each falling edge of X2 into a FIFO and sends
// every record as SYNC_BYTE, TRACE, OUTPUT over a single UART line.
module mc14500b_trace_uart
  import mc14500b_trace_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 104,
  parameter int         FIFO_DEPTH   = 16,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       X2,
  input  logic       ENABLE,
  input  logic [7:0] TRACE,
  input  logic [7:0] OUTPUT,
  output logic       TX,
  output logic       BUSY,
  output logic [7:0] DROPPED
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(FIFO_DEPTH);

  logic            x2_q;
  trace_rec_t      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q, count_d;
  logic [7:0]      dropped_q;
  seq_state_e      seq_q;
  trace_rec_t      hold_q;

  logic       capture_s, nonempty_s, full_s, pop_s, push_s, drop_s;
  logic       tx_ready_s, tx_valid_s;
  logic [7:0] tx_data_s;

  // A pop is also the hand-off of the sync byte, so it only happens when the
  // transmitter is free and the sequencer is between records.
  always_comb begin
    capture_s  = x2_q & ~X2 & ENABLE;
    nonempty_s = (count_q != '0);
    full_s     = (count_q == DEPTH_C);
    pop_s      = tx_ready_s & nonempty_s & ((seq_q == S_IDLE) | (seq_q == S_OUT));
    push_s     = capture_s & (~full_s | pop_s);
    drop_s     = capture_s & full_s & ~pop_s;
    count_d    = count_q + CNTW'(push_s) - CNTW'(pop_s);
  end

  // Byte offered to the transmitter for the current sequencer state.
  always_comb begin
    tx_valid_s = 1'b0;
    tx_data_s  = SYNC_BYTE;
    case (seq_q)
      S_IDLE: tx_valid_s = nonempty_s;
      S_SYNC: begin
        tx_valid_s = 1'b1;
        tx_data_s  = hold_q.trace;
      end
      S_TRC: begin
        tx_valid_s = 1'b1;
        tx_data_s  = hold_q.out;
      end
      S_OUT:   tx_valid_s = nonempty_s;
      default: tx_valid_s = 1'b0;
    endcase
  end

  // Strobe history, FIFO pointers/occupancy and the saturating drop counter.
  always_ff @(posedge CLK) begin
    x2_q <= X2;
    if (RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dropped_q <= 8'h00;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (drop_s && (dropped_q != 8'hFF)) dropped_q <= dropped_q + 8'h01;
    end
  end

  // Record storage; contents are don't-care until the pointers cover them.
  always_ff @(posedge CLK) begin
    if (push_s) mem_q[wr_ptr_q] <= '{trace: TRACE, out: OUTPUT};
  end

  // Record sequencer: each state names the byte currently on the line.
  always_ff @(posedge CLK) begin
    if (RST) begin
      seq_q  <= S_IDLE;
      hold_q <= '0;
    end else begin
      case (seq_q)
        S_IDLE: begin
          if (pop_s) begin
            hold_q <= mem_q[rd_ptr_q];
            seq_q  <= S_SYNC;
          end
        end
        S_SYNC: if (tx_ready_s) seq_q <= S_TRC;
        S_TRC:  if (tx_ready_s) seq_q <= S_OUT;
        S_OUT: begin
          if (pop_s) begin
            hold_q <= mem_q[rd_ptr_q];
            seq_q  <= S_SYNC;
          end else if (tx_ready_s) begin
            seq_q <= S_IDLE;
          end
        end
        default: seq_q <= S_IDLE;
      endcase
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .CLK  (CLK),
    .RST  (RST),
    .data (tx_data_s),
    .valid(tx_valid_s),
    .ready(tx_ready_s),
    .TX   (TX)
  );

  assign BUSY    = (seq_q != S_IDLE) | nonempty_s;
  assign DROPPED = dropped_q;

endmodule

// File: tb/tb_mc14500b_trace_uart.sv
// Bench for mc14500b_trace_uart: directed vector table, hand-written corner
// sequences and random traffic, all compared every cycle against a record-level model.
module tb_mc14500b_trace_uart;

  localparam int C    = 4;
  localparam int D    = 2;
  localparam int REC  = 30 * C;
  localparam int MAXC = 16384;
  localparam int MAXR = 2048;

  logic       CLK = 1'b0, RST = 1'b1, X2 = 1'b0, ENABLE = 1'b0;
  logic [7:0] TRACE = 8'h00, OUTPUT = 8'h00;
  logic       TX, BUSY;
  logic [7:0] DROPPED;

  int n_checks = 0, n_errors = 0;
  int cyc = 0;
  bit chk_on = 1'b0;
  logic tx_hist [MAXC];
  logic busy_hist [MAXC];
  logic [7:0] rx_q [$];

  // Record-level model: capture cycle, pop cycle and payload per accepted record.
  int         m_c [MAXR];
  int         m_p [MAXR];
  logic [7:0] m_tr [MAXR];
  logic [7:0] m_ou [MAXR];
  int         n_acc = 0, n_drop = 0, last_drop = -1;
  logic       x2_prev = 1'b0;

  typedef struct {
    logic       en;
    logic [7:0] tr;
    logic [7:0] ou;
    int         recs;
  } vec_t;
  vec_t tbl [5];

  int n, n0, s, b, p_hit;
  logic x2n;
  int dens;

  mc14500b_trace_uart #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (D),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .X2     (X2),
    .ENABLE (ENABLE),
    .TRACE  (TRACE),
    .OUTPUT (OUTPUT),
    .TX     (TX),
    .BUSY   (BUSY),
    .DROPPED(DROPPED)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic exp_tx(input int t);
    logic [7:0] v;
    int o, ph;
    for (int k = 0; k < n_acc; k++) begin
      if (t > m_p[k] && t <= m_p[k] + REC) begin
        o  = t - m_p[k] - 1;
        ph = o % (10 * C);
        case (o / (10 * C))
          0:       v = 8'hA5;
          1:       v = m_tr[k];
          default: v = m_ou[k];
        endcase
        if (ph < C) return 1'b0;
        if (ph >= 9 * C) return 1'b1;
        return v[ph / C - 1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int t);
    for (int k = 0; k < n_acc; k++)
      if (m_c[k] < t && t <= m_p[k] + REC) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] exp_drop(input int t);
    int v;
    v = n_drop - ((last_drop == t) ? 1 : 0);
    return (v > 255) ? 8'hFF : 8'(v);
  endfunction

  task automatic model_cycle();
    int t, occ;
    bit popnow;
    t = cyc;
    if (RST) begin
      n_acc = 0; n_drop = 0; last_drop = -1;
    end else if (x2_prev && !X2 && ENABLE) begin
      occ = 0; popnow = 1'b0;
      for (int k = 0; k < n_acc; k++) begin
        if (m_p[k] >= t) occ++;
        if (m_p[k] == t) popnow = 1'b1;
      end
      if ((occ < D || popnow) && n_acc < MAXR) begin
        m_c[n_acc]  = t;
        m_p[n_acc]  = (n_acc == 0 || m_p[n_acc-1] + REC < t + 1) ? t + 1 : m_p[n_acc-1] + REC;
        m_tr[n_acc] = TRACE;
        m_ou[n_acc] = OUTPUT;
        n_acc++;
      end else begin
        n_drop++;
        last_drop = t;
      end
    end
    x2_prev = X2;
  endtask

  // Every non-reset cycle: line level, BUSY and DROPPED against the model.
  always @(negedge CLK) begin
    if (cyc < MAXC) begin
      tx_hist[cyc]   = TX;
      busy_hist[cyc] = BUSY;
    end
    if (chk_on && !RST) begin
      check("tx_line", 32'(TX), 32'(exp_tx(cyc)));
      check("busy", 32'(BUSY), 32'(exp_busy(cyc)));
      check("dropped", 32'(DROPPED), 32'(exp_drop(cyc)));
    end
  end

  task automatic step(input logic rst, input logic x2, input logic en,
                      input logic [7:0] tr, input logic [7:0] ou);
    @(posedge CLK);
    #1;
    RST = rst; X2 = x2; ENABLE = en; TRACE = tr; OUTPUT = ou;
    model_cycle();
  endtask

  task automatic hold(input int cnt);
    for (int i = 0; i < cnt; i++) step(1'b0, X2, ENABLE, TRACE, OUTPUT);
  endtask

  task automatic do_reset();
    step(1'b1, X2, 1'b0, TRACE, OUTPUT);
    step(1'b1, X2, 1'b0, TRACE, OUTPUT);
    step(1'b0, X2, 1'b0, TRACE, OUTPUT);
  endtask

  task automatic strobe(input logic en, input logic [7:0] tr, input logic [7:0] ou, output int at);
    step(1'b0, 1'b1, en, tr, ou);
    step(1'b0, 1'b0, en, tr, ou);
    at = cyc;
  endtask

  task automatic decode(input int from, input int to);
    int p;
    logic [7:0] v;
    rx_q.delete();
    p = from;
    while (p < to && p + 10 * C < MAXC) begin
      if (tx_hist[p] === 1'b0) begin
        for (int i = 0; i < 8; i++) v[i] = tx_hist[p + C * (i + 1) + C / 2];
        check("stop_bit", 32'(tx_hist[p + 9 * C + C / 2]), 32'd1);
        rx_q.push_back(v);
        p += 10 * C;
      end else begin
        p++;
      end
    end
  endtask

  function automatic int count_zeros(input int from, input int to);
    int z = 0;
    for (int i = from; i < to && i < MAXC; i++) if (tx_hist[i] !== 1'b1) z++;
    return z;
  endfunction

  function automatic int first_fall(input int from, input int to);
    for (int i = from; i < to && i < MAXC; i++) if (tx_hist[i] === 1'b0) return i;
    return -1;
  endfunction

  function automatic int first_busy_low(input int from, input int to);
    for (int i = from; i < to && i < MAXC; i++) if (busy_hist[i] === 1'b0) return i;
    return -1;
  endfunction

  task automatic check_rec(input int base, input logic [7:0] tr, input logic [7:0] ou);
    if (rx_q.size() >= base + 3) begin
      check("rec_sync", 32'(rx_q[base]), 32'h0A5);
      check("rec_trace", 32'(rx_q[base + 1]), 32'(tr));
      check("rec_output", 32'(rx_q[base + 2]), 32'(ou));
    end else begin
      check("rec_present", 32'(rx_q.size()), 32'(base + 3));
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'h3C, 8'h05, 1};
    tbl[1] = '{1'b0, 8'hFF, 8'h00, 0};
    tbl[2] = '{1'b1, 8'h00, 8'hFF, 1};
    tbl[3] = '{1'b1, 8'h81, 8'h7E, 1};
    tbl[4] = '{1'b0, 8'h12, 8'h34, 0};

    do_reset();
    chk_on = 1'b1;
    check("reset_tx", 32'(TX), 32'd1);
    check("reset_busy", 32'(BUSY), 32'd0);
    check("reset_dropped", 32'(DROPPED), 32'd0);

    for (int i = 0; i < 5; i++) begin
      strobe(tbl[i].en, tbl[i].tr, tbl[i].ou, n);
      hold(REC + 10);
      decode(n, cyc);
      check("vec_nbytes", 32'(rx_q.size()), 32'(3 * tbl[i].recs));
      if (tbl[i].recs == 1) begin
        check_rec(0, tbl[i].tr, tbl[i].ou);
        s = first_fall(n, cyc);
        check("start_latency", 32'(s - n), 32'd2);
        b = first_busy_low(s, cyc);
        check("record_cycles", 32'(b - s), 32'(REC));
      end else begin
        check("disabled_line_idle", 32'(count_zeros(n, cyc)), 32'd0);
        check("disabled_busy", 32'(BUSY), 32'd0);
      end
    end

    // Overflow: six strobes two cycles apart into a two-deep FIFO.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      strobe(1'b1, 8'(8'h10 + i), 8'(8'hE0 + i), n);
      if (i == 0) n0 = n;
    end
    hold(3 * REC + 30);
    check("overflow_dropped", 32'(DROPPED), 32'd3);
    decode(n0, cyc);
    check("overflow_nbytes", 32'(rx_q.size()), 32'd9);
    for (int r = 0; r < 3; r++) check_rec(3 * r, 8'(8'h10 + r), 8'(8'hE0 + r));

    // ENABLE low ignores strobes; dropping it mid-record finishes the record.
    do_reset();
    n0 = cyc;
    for (int i = 0; i < 4; i++) strobe(1'b0, 8'(8'h55 + i), 8'h66, n);
    hold(40);
    check("en0_line_idle", 32'(count_zeros(n0, cyc)), 32'd0);
    check("en0_busy", 32'(BUSY), 32'd0);
    check("en0_dropped", 32'(DROPPED), 32'd0);
    strobe(1'b1, 8'hC3, 8'h5A, n);
    hold(20);
    step(1'b0, X2, 1'b0, 8'h00, 8'h00);
    strobe(1'b0, 8'h11, 8'h22, b);
    hold(REC);
    decode(n, cyc);
    check("en_drop_nbytes", 32'(rx_q.size()), 32'd3);
    check_rec(0, 8'hC3, 8'h5A);

    // Reset during the TRACE byte's data bits with two records queued.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      strobe(1'b1, 8'(8'h21 + i), 8'(8'h31 + i), n);
      if (i == 0) n0 = n;
    end
    hold(n0 + 56 - cyc);
    step(1'b1, X2, 1'b1, TRACE, OUTPUT);
    step(1'b0, X2, 1'b1, TRACE, OUTPUT);
    check("midreset_tx", 32'(TX), 32'd1);
    check("midreset_busy", 32'(BUSY), 32'd0);
    check("midreset_dropped", 32'(DROPPED), 32'd0);
    n0 = cyc;
    hold(300);
    check("midreset_silent", 32'(count_zeros(n0, cyc)), 32'd0);
    strobe(1'b1, 8'h77, 8'h88, n);
    hold(REC + 10);
    decode(n, cyc);
    check("midreset_restart_nbytes", 32'(rx_q.size()), 32'd3);
    check_rec(0, 8'h77, 8'h88);

    // Strobe on the exact cycle a full FIFO is popped.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      strobe(1'b1, 8'(8'h40 + i), 8'(8'hB0 + i), n);
      if (i == 0) n0 = n;
    end
    p_hit = m_p[1];
    while (cyc < p_hit - 1) step(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h4F, 8'hBF);
    hold(10);
    check("simul_dropped", 32'(DROPPED), 32'd0);
    hold(3 * REC + 20);
    decode(n0, cyc);
    check("simul_nbytes", 32'(rx_q.size()), 32'd12);
    check_rec(9, 8'h4F, 8'hBF);

    // Saturation: far more than 255 lost strobes.
    do_reset();
    for (int i = 0; i < 320; i++) strobe(1'b1, 8'($urandom), 8'($urandom), n);
    check("sat_dropped", 32'(DROPPED), 32'd255);
    hold(3 * REC + 40);
    check("sat_drained_busy", 32'(BUSY), 32'd0);
    check("sat_dropped_hold", 32'(DROPPED), 32'd255);

    // Random traffic of varying density with rare resets.
    do_reset();
    dens = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) dens = int'($urandom_range(1, 40));
      x2n = ($urandom_range(0, dens - 1) == 0) ? ~X2 : X2;
      step(($urandom_range(0, 1499) == 0), x2n, ($urandom_range(0, 7) != 0),
           8'($urandom), 8'($urandom));
    end
    hold(3 * REC + 40);
    check("random_drained_busy", 32'(BUSY), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
